// File: rtl/fp32_add_core_if.sv
// Operand/result handshake bundle for fp32_add_core.
// Optional macro FPADD_SUB_EN adds the op_sub operand-control bit.
interface fp32_add_core_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
`ifdef FPADD_SUB_EN
    logic        op_sub;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        flag_clr;

`ifdef FPADD_SUB_EN
    modport master (
        output in_valid, op_a, op_b, op_sub, out_ready, flag_clr,
        input  in_ready, out_valid, result, flags
    );
    modport slave (
        input  in_valid, op_a, op_b, op_sub, out_ready, flag_clr,
        output in_ready, out_valid, result, flags
    );
`else
    modport master (
        output in_valid, op_a, op_b, out_ready, flag_clr,
        input  in_ready, out_valid, result, flags
    );
    modport slave (
        input  in_valid, op_a, op_b, out_ready, flag_clr,
        output in_ready, out_valid, result, flags
    );
`endif
endinterface

// File: rtl/fp32_add_core.sv
// Multi-cycle IEEE-754 binary32 adder, round-to-nearest-even, subnormals flushed to zero.
// One operation in flight: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> OUT.
// Optional macro FPADD_SUB_EN adds op_sub (flip op_b sign at accept for subtraction).
// flags = {invalid, overflow, underflow, inexact}.
module fp32_add_core #(
    parameter bit FLAG_STICKY = 1'b1
) (
    input  logic           S_AXI_ACLK,
    input  logic           S_AXI_ARESET,
    fp32_add_core_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle, StUnpack, StAlign, StAdd, StNorm, StRound, StOut
    } state_e;

    state_e state_q, state_d;

    // Operand registers (captured at accept)
    logic [31:0] a_q, b_q;
    logic [31:0] b_eff;

    // Unpack stage registers
    logic        special_q;
    logic [31:0] spec_res_q;
    logic [3:0]  spec_flags_q;
    logic        sign_q;
    logic        eff_sub_q;
    logic [7:0]  exp_q;
    logic [23:0] mx_q, my_q;
    logic [7:0]  diff_q;

    // Align / add / norm stage registers
    logic [26:0]        my_al_q;
    logic [27:0]        sum_q;
    logic [26:0]        norm_q;
    logic signed [9:0]  nexp_q;
    logic               zero_q;

    // Output registers
    logic [31:0] result_q;
    logic [3:0]  flags_q, flags_d;

    // Unpack combinational signals
    logic        u_special;
    logic [31:0] u_spec_res;
    logic [3:0]  u_spec_flags;
    logic        u_sign, u_eff_sub;
    logic [7:0]  u_exp, u_diff;
    logic [23:0] u_mx, u_my;

    // Align / add / norm / round combinational signals
    logic [4:0]         shamt;
    logic [53:0]        wide;
    logic [26:0]        al_y;
    logic [27:0]        sum_d;
    logic [4:0]         lz;
    logic [26:0]        norm_d;
    logic signed [9:0]  nexp_d;
    logic               rup, inexact;
    logic [24:0]        mant25;
    logic signed [9:0]  rexp;
    logic [22:0]        frac;
    logic [31:0]        rnd_res;
    logic [3:0]         rnd_flags;

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StOut);
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

    // Subtraction is folded into the operand: NaN sign is irrelevant to the canonical result
`ifdef FPADD_SUB_EN
    assign b_eff = {bus.op_b[31] ^ bus.op_sub, bus.op_b[30:0]};
`else
    assign b_eff = bus.op_b;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (bus.in_valid) state_d = StUnpack;
            StUnpack: state_d = StAlign;
            StAlign:  state_d = StAdd;
            StAdd:    state_d = StNorm;
            StNorm:   state_d = StRound;
            StRound:  state_d = StOut;
            StOut:    if (bus.out_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Classify operands, resolve special cases, order by magnitude
    always_comb begin
        logic        sa, sb;
        logic [7:0]  ea, eb, ea_f, eb_f;
        logic [22:0] fa, fb;
        logic        a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
        logic [23:0] ma, mb;
        logic        a_ge;
        sa     = a_q[31];
        sb     = b_q[31];
        ea     = a_q[30:23];
        eb     = b_q[30:23];
        fa     = a_q[22:0];
        fb     = b_q[22:0];
        a_nan  = (&ea) && (|fa);
        b_nan  = (&eb) && (|fb);
        a_snan = a_nan && !fa[22];
        b_snan = b_nan && !fb[22];
        a_inf  = (&ea) && !(|fa);
        b_inf  = (&eb) && !(|fb);
        // Subnormals are treated as zero
        a_zero = (ea == 8'd0);
        b_zero = (eb == 8'd0);
        ma     = a_zero ? 24'd0 : {1'b1, fa};
        mb     = b_zero ? 24'd0 : {1'b1, fb};
        ea_f   = a_zero ? 8'd0 : ea;
        eb_f   = b_zero ? 8'd0 : eb;

        u_special    = 1'b1;
        u_spec_res   = 32'd0;
        u_spec_flags = 4'd0;
        if (a_nan || b_nan) begin
            u_spec_res   = 32'h7FC0_0000;
            u_spec_flags = {a_snan | b_snan, 3'b000};
        end else if (a_inf && b_inf) begin
            if (sa == sb) begin
                u_spec_res = {sa, 8'hFF, 23'd0};
            end else begin
                u_spec_res   = 32'h7FC0_0000;
                u_spec_flags = 4'b1000;
            end
        end else if (a_inf) begin
            u_spec_res = {sa, 8'hFF, 23'd0};
        end else if (b_inf) begin
            u_spec_res = {sb, 8'hFF, 23'd0};
        end else if (a_zero && b_zero) begin
            u_spec_res = {sa & sb, 31'd0};
        end else begin
            u_special = 1'b0;
        end

        // Larger magnitude becomes x so the difference is never negative
        a_ge      = ({ea_f, ma} >= {eb_f, mb});
        u_sign    = a_ge ? sa : sb;
        u_eff_sub = sa ^ sb;
        u_exp     = a_ge ? ea_f : eb_f;
        u_mx      = a_ge ? ma : mb;
        u_my      = a_ge ? mb : ma;
        u_diff    = a_ge ? (ea_f - eb_f) : (eb_f - ea_f);
    end

    // Align the smaller operand; shifted-out bits collapse into sticky
    always_comb begin
        shamt = (diff_q > 8'd27) ? 5'd27 : diff_q[4:0];
        wide  = {my_q, 3'b000, 27'd0} >> shamt;
        al_y  = {wide[53:28], wide[27] | (|wide[26:0])};
    end

    // Magnitude add or subtract with carry bit
    always_comb begin
        if (eff_sub_q) begin
            sum_d = {1'b0, mx_q, 3'b000} - {1'b0, my_al_q};
        end else begin
            sum_d = {1'b0, mx_q, 3'b000} + {1'b0, my_al_q};
        end
    end

    // Normalise: right by one on carry-out, else left by leading-zero count
    always_comb begin
        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (sum_q[i]) lz = 5'(26 - i);
        end
        if (sum_q[27]) begin
            norm_d = {sum_q[27:2], sum_q[1] | sum_q[0]};
            nexp_d = $signed({2'b00, exp_q}) + 10'sd1;
        end else begin
            norm_d = sum_q[26:0] << lz;
            nexp_d = $signed({2'b00, exp_q}) - $signed({5'd0, lz});
        end
    end

    // Round to nearest even and pack, with overflow/underflow handling
    always_comb begin
        inexact = norm_q[2] | norm_q[1] | norm_q[0];
        rup     = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
        mant25  = {1'b0, norm_q[26:3]} + 25'(rup);
        rexp    = nexp_q + (mant25[24] ? 10'sd1 : 10'sd0);
        frac    = mant25[24] ? mant25[23:1] : mant25[22:0];
        if (special_q) begin
            rnd_res   = spec_res_q;
            rnd_flags = spec_flags_q;
        end else if (zero_q) begin
            rnd_res   = 32'd0;
            rnd_flags = 4'd0;
        end else if (nexp_q <= 10'sd0) begin
            rnd_res   = {sign_q, 31'd0};
            rnd_flags = 4'b0011;
        end else if (rexp >= 10'sd255) begin
            rnd_res   = {sign_q, 8'hFF, 23'd0};
            rnd_flags = 4'b0101;
        end else begin
            rnd_res   = {sign_q, rexp[7:0], frac};
            rnd_flags = {3'b000, inexact};
        end
    end

    // Flag update: clear applies before the new result's flags are merged
    always_comb begin
        logic [3:0] base;
        base    = bus.flag_clr ? 4'd0 : flags_q;
        flags_d = base;
        if (state_q == StRound) begin
            flags_d = FLAG_STICKY ? (base | rnd_flags) : rnd_flags;
        end
    end

    // Control and architectural output registers
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state_q  <= StIdle;
            result_q <= 32'd0;
            flags_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            if (state_q == StRound) result_q <= rnd_res;
        end
    end

    // Datapath stage registers, each loaded in its own state
    always_ff @(posedge S_AXI_ACLK) begin
        if (state_q == StIdle && bus.in_valid) begin
            a_q <= bus.op_a;
            b_q <= b_eff;
        end
        if (state_q == StUnpack) begin
            special_q    <= u_special;
            spec_res_q   <= u_spec_res;
            spec_flags_q <= u_spec_flags;
            sign_q       <= u_sign;
            eff_sub_q    <= u_eff_sub;
            exp_q        <= u_exp;
            mx_q         <= u_mx;
            my_q         <= u_my;
            diff_q       <= u_diff;
        end
        if (state_q == StAlign) my_al_q <= al_y;
        if (state_q == StAdd)   sum_q   <= sum_d;
        if (state_q == StNorm) begin
            norm_q <= norm_d;
            nexp_q <= nexp_d;
            zero_q <= (sum_q == 28'd0);
        end
    end

endmodule

// File: tb/tb_fp32_add_core.sv
// Directed-vector bench for fp32_add_core with hand-computed results.
// Define FPADD_SUB_EN to also exercise the op_sub path.
module tb_fp32_add_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fp32_add_core_if bus ();

    fp32_add_core #(
        .FLAG_STICKY (1'b1)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .bus          (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        bus.flag_clr = 1'b1;
        step();
        bus.flag_clr = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            step();
            n++;
        end
        check_eq("in_ready_at_issue", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
`ifdef FPADD_SUB_EN
        bus.op_sub   = sub;
`else
        if (sub) $display("note: op_sub ignored in this build");
`endif
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (bus.out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check_eq("in_ready_after_take", 32'(bus.in_ready), 32'd1);
    endtask

    // clr_mode: 0 none, 1 pulse before issue, 2 held high throughout
    task automatic do_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input int clr_mode,
                          input logic [31:0] exp_res, input logic [3:0] exp_flg);
        int lat;
        if (clr_mode == 1) pulse_clr();
        if (clr_mode == 2) bus.flag_clr = 1'b1;
        issue(a, b, sub);
        wait_out(lat);
        check_eq({tag, "_lat"}, 32'(lat), 32'd5);
        check_eq({tag, "_res"}, bus.result, exp_res);
        check_eq({tag, "_flags"}, 32'(bus.flags), 32'(exp_flg));
        bus.flag_clr = 1'b0;
        consume();
    endtask

    initial begin
        int lat;
        int seen;
        logic [31:0] held;
        bus.in_valid  = 1'b0;
        bus.op_a      = 32'd0;
        bus.op_b      = 32'd0;
`ifdef FPADD_SUB_EN
        bus.op_sub    = 1'b0;
`endif
        bus.out_ready = 1'b0;
        bus.flag_clr  = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_result", bus.result, 32'd0);
        check_eq("rst_flags", 32'(bus.flags), 32'd0);

        do_vec("one_plus_two", 32'h3F80_0000, 32'h4000_0000, 1'b0, 1, 32'h4040_0000, 4'b0000);
        do_vec("max_plus_max", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 1, 32'h7F80_0000, 4'b0101);
        do_vec("inf_minus_inf", 32'h7F80_0000, 32'hFF80_0000, 1'b0, 1, 32'h7FC0_0000, 4'b1000);
        pulse_clr();
        check_eq("flag_clr", 32'(bus.flags), 32'd0);
        do_vec("tie_even", 32'h3F80_0000, 32'h3380_0000, 1'b0, 1, 32'h3F80_0000, 4'b0001);
        // Sticky accumulation: no clear between ops
        do_vec("sticky_acc", 32'h7F80_0000, 32'hFF80_0000, 1'b0, 0, 32'h7FC0_0000, 4'b1001);
        // Clear coinciding with update leaves only the new flags
        do_vec("clr_coincide", 32'h3F80_0000, 32'h3380_0000, 1'b0, 2, 32'h3F80_0000, 4'b0001);
        do_vec("tie_round_up", 32'h3F80_0001, 32'h3380_0000, 1'b0, 1, 32'h3F80_0002, 4'b0001);
        do_vec("carry_norm", 32'h3FC0_0000, 32'h3FC0_0000, 1'b0, 1, 32'h4040_0000, 4'b0000);
        do_vec("underflow", 32'h0080_0001, 32'h8080_0000, 1'b0, 1, 32'h0000_0000, 4'b0011);
        do_vec("neg0_neg0", 32'h8000_0000, 32'h8000_0000, 1'b0, 1, 32'h8000_0000, 4'b0000);
        do_vec("cancel_pos0", 32'h3F80_0000, 32'hBF80_0000, 1'b0, 1, 32'h0000_0000, 4'b0000);
        do_vec("qnan_in", 32'h7FC0_0001, 32'h3F80_0000, 1'b0, 1, 32'h7FC0_0000, 4'b0000);
        do_vec("snan_in", 32'h7F80_0001, 32'h3F80_0000, 1'b0, 1, 32'h7FC0_0000, 4'b1000);
        do_vec("inf_plus_one", 32'hFF80_0000, 32'h3F80_0000, 1'b0, 1, 32'hFF80_0000, 4'b0000);
        do_vec("subnorm_flush", 32'h3F80_0000, 32'h0000_0001, 1'b0, 1, 32'h3F80_0000, 4'b0000);
`ifdef FPADD_SUB_EN
        do_vec("sub_self", 32'h4040_0000, 32'h4040_0000, 1'b1, 1, 32'h0000_0000, 4'b0000);
`endif

        // Backpressure: result and in_ready hold while out_ready is low
        issue(32'h3F80_0000, 32'h4000_0000, 1'b0);
        wait_out(lat);
        check_eq("bp_lat", 32'(lat), 32'd5);
        held = bus.result;
        check_eq("bp_res", held, 32'h4040_0000);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("bp_stable", bus.result, 32'h4040_0000);
            check_eq("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check_eq("bp_out_valid", 32'(bus.out_valid), 32'd1);
        end
        consume();

        // Reset while in ALIGN aborts the operation
        issue(32'h3F80_0000, 32'h4000_0000, 1'b0);
        step();
        rst = 1'b1;
        step();
        check_eq("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("abort_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.out_valid) seen++;
        end
        check_eq("abort_no_result", 32'(seen), 32'd0);
        check_eq("abort_result", bus.result, 32'd0);
        check_eq("abort_flags", 32'(bus.flags), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fp32_add_core.md
FP32_ADD_CORE -- requirements
Module: fp32_add_core

Interface
REQ-001 SHALL have parameter FLAG_STICKY, default 1: 1 = flags OR-accumulate across operations until flag_clr; 0 = flags reflect the last result only.
REQ-002 SHALL have port S_AXI_ACLK, input, 1: sole clock; all logic on rising edge.
REQ-003 SHALL have port S_AXI_ARESET, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1: operands valid.
REQ-005 SHALL have port in_ready, output, 1: core idle, can accept operands.
REQ-006 SHALL have port op_a, input, 32: IEEE-754 binary32 operand A (AXI-Lite slave register 0).
REQ-007 SHALL have port op_b, input, 32: binary32 operand B (slave register 1).
REQ-008 SHALL have port out_valid, output, 1: result valid.
REQ-009 SHALL have port out_ready, input, 1: consumer (slave register 2 read path) accepts result.
REQ-010 SHALL have port result, output, 32: binary32 sum.
REQ-011 SHALL have port flags, output, 4: {invalid, overflow, underflow, inexact}.
REQ-012 SHALL have port flag_clr, input, 1: clears flags.

Function
REQ-013 SHALL use an FSM: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> OUT -> IDLE, one cycle per state except OUT.
REQ-014 SHALL assert in_ready only in IDLE; an operand transfer occurs when in_valid && in_ready, and operands SHALL be registered on that edge.
REQ-015 SHALL assert out_valid exactly 5 cycles after the accept edge and hold result/flags stable until out_valid && out_ready.
REQ-016 SHALL return to IDLE on the out_valid && out_ready edge; in_ready SHALL rise the following cycle (one op in flight; back-to-back issue period 7 cycles minimum).
REQ-017 SHALL extend mantissas to 24 bits (hidden bit) plus guard, round and sticky (27 bits) and form a 28-bit sum/difference.
REQ-018 SHALL right-shift the smaller-exponent operand by the exponent difference, saturating at 27; all shifted-out bits SHALL OR into sticky.
REQ-019 SHALL normalise with a leading-zero count (left shift) or a 1-bit right shift on carry-out, adjusting the exponent accordingly.
REQ-020 SHALL round to nearest, ties to even; a mantissa carry from rounding SHALL increment the exponent.
REQ-021 SHALL flush subnormal inputs to signed zero; a nonzero result below the minimum normal SHALL flush to signed zero and set underflow and inexact.
REQ-022 SHALL produce 0x7F800000/0xFF800000 on overflow, setting overflow and inexact.
REQ-023 SHALL return canonical NaN 0x7FC00000 for any NaN input or for +inf + -inf; invalid SHALL be set for inf - inf or a signalling-NaN input.
REQ-024 SHALL return inf of matching sign for inf + finite or for inf + inf of the same sign, with no flags.
REQ-025 SHALL return +0 for an exact zero sum of opposite-sign operands, and -0 only for -0 + -0.
REQ-026 SHALL set inexact when guard|round|sticky is nonzero before rounding.
REQ-027 SHALL, when flag_clr and a flag update coincide, apply the clear first and then the new flags.

Reset
REQ-028 SHALL, on S_AXI_ARESET, set the FSM to IDLE, in_ready=1 on the next cycle, out_valid=0, result=0x00000000 and flags=0.
REQ-029 SHALL, on reset mid-operation, abort the in-flight operation with no result emitted.

Configuration
REQ-030 SHALL, when FPADD_SUB_EN is defined, add port op_sub, input, 1, registered at accept; op_sub=1 SHALL invert op_b's sign before UNPACK, and NaN inputs SHALL be unaffected.
REQ-031 SHALL, when FPADD_SUB_EN is undefined, omit op_sub and perform addition only.

Verification
REQ-032 SHALL verify 0x3F800000 + 0x40000000 -> result 0x40400000, flags 0, out_valid 5 cycles after accept.
REQ-033 SHALL verify 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, flags 0b0101.
REQ-034 SHALL verify 0x7F800000 + 0xFF800000 -> 0x7FC00000, flags 0b1000; then flag_clr -> flags 0 (FLAG_STICKY=1).
REQ-035 SHALL verify 0x3F800000 + 0x33800000 (tie) -> 0x3F800000, flags 0b0001.
REQ-036 SHALL verify that with out_ready held low for 3 cycles, result stays stable and in_ready stays 0; and that S_AXI_ARESET asserted in the ALIGN state gives out_valid=0 and in_ready=1 the next cycle.
REQ-037 SHALL verify, with FPADD_SUB_EN defined, op_sub=1 and 0x40400000 - 0x40400000 -> 0x00000000, flags 0.
